if_stage: RTL and testbench

- Instruction-fetch stage directly upstream of decode.
- Owns the PC and drives a req/ack instruction-memory port.
- Holds the IF/ID pipeline register that feeds decode its PC and instruction.
- Handles decode stalls and redirects: a jump resolved in decode, or a taken branch resolved in execute.

---
 rtl/if_stage_pkg.sv | 22 ++
 rtl/if_id_reg.sv | 40 ++++
 rtl/if_stage.sv | 155 +++++++++++++++
 tb/tb_if_stage.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared types, constants and helpers for the instruction-fetch stage.
package if_stage_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned JIDX_W = 26;

  localparam logic [INST_W-1:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    StStart,
    StFetch,
    StHold,
    StDiscard
  } if_state_e;

  // Region bits come from the PC+4 of the jump itself, as decode sees it.
  function automatic logic [INST_W-1:0] jump_target(input logic [INST_W-1:0] pc4,
                                                    input logic [JIDX_W-1:0] idx);
    return {pc4[INST_W-1:INST_W-4], idx, 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: clear beats load, otherwise hold.
module if_id_reg
  import if_stage_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [INST_W-1:0] pc_i,
  input  logic [INST_W-1:0] inst_i,
  output logic [INST_W-1:0] pc_o,
  output logic [INST_W-1:0] inst_o,
  output logic              valid_o
);

  logic [INST_W-1:0] pc_q;
  logic [INST_W-1:0] inst_q;
  logic              valid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q    <= '0;
      inst_q  <= NOP;
      valid_q <= 1'b0;
    end else if (clear_i) begin
      pc_q    <= '0;
      inst_q  <= NOP;
      valid_q <= 1'b0;
    end else if (load_i) begin
      pc_q    <= pc_i;
      inst_q  <= inst_i;
      valid_q <= 1'b1;
    end
  end

  assign pc_o    = pc_q;
  assign inst_o  = inst_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, req/ack imem port, skid buffer and IF/ID register.
// Define IF_PERF_CNT_EN to add fetch_cnt / bubble_cnt performance counters.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [INST_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [INST_W-1:0] branch_target,
  input  logic              jump,
  input  logic [JIDX_W-1:0] jump_index,
  output logic              imem_req,
  output logic [INST_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] IFtoID_PC,
  output logic [INST_W-1:0] IFtoID_inst,
  output logic              IFtoID_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  if_state_e         state_q, state_d;
  logic [INST_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] pend_pc_q, pend_pc_d;
  logic [INST_W-1:0] buf_pc_q, buf_pc_d;
  logic [INST_W-1:0] buf_inst_q, buf_inst_d;

  logic              redirect;
  logic [INST_W-1:0] target;
  logic [INST_W-1:0] pc_inc;
  logic              ifid_load;
  logic              ifid_clear;
  logic [INST_W-1:0] ifid_pc;
  logic [INST_W-1:0] ifid_inst;

  assign redirect = branch_taken | jump;
  assign target   = branch_taken ? (branch_target & ~32'h3)
                                 : jump_target(IFtoID_PC, jump_index);
  assign pc_inc   = pc_q + 32'd4;

  assign imem_req  = (state_q == StFetch) || (state_q == StDiscard);
  assign imem_addr = pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_pc_d  = pend_pc_q;
    buf_pc_d   = buf_pc_q;
    buf_inst_d = buf_inst_q;
    ifid_load  = 1'b0;
    ifid_pc    = pc_inc;
    ifid_inst  = imem_rdata;
    unique case (state_q)
      StStart: begin
        state_d = StFetch;
        if (redirect) pc_d = target;
      end
      StFetch: begin
        if (imem_ack) begin
          if (redirect) begin
            pc_d = target;
          end else if (!stall) begin
            ifid_load = 1'b1;
            pc_d      = pc_inc;
          end else begin
            buf_pc_d   = pc_inc;
            buf_inst_d = imem_rdata;
            state_d    = StHold;
          end
        end else if (redirect) begin
          // Request must stay stable until acked; remember where to go after.
          pend_pc_d = target;
          state_d   = StDiscard;
        end
      end
      StHold: begin
        if (redirect) begin
          pc_d    = target;
          state_d = StFetch;
        end else if (!stall) begin
          ifid_load = 1'b1;
          ifid_pc   = buf_pc_q;
          ifid_inst = buf_inst_q;
          pc_d      = pc_inc;
          state_d   = StFetch;
        end
      end
      StDiscard: begin
        if (redirect) pend_pc_d = target;
        if (imem_ack) begin
          pc_d    = redirect ? target : pend_pc_q;
          state_d = StFetch;
        end
      end
      default: state_d = StStart;
    endcase
  end

  // Decode consumed the old entry and nothing new arrived: insert a bubble.
  assign ifid_clear = redirect | (!stall & !ifid_load);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StStart;
      pc_q       <= RESET_PC;
      pend_pc_q  <= '0;
      buf_pc_q   <= '0;
      buf_inst_q <= NOP;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
      buf_pc_q   <= buf_pc_d;
      buf_inst_q <= buf_inst_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk_i  (clk),
    .rst_ni (rst),
    .load_i (ifid_load),
    .clear_i(ifid_clear),
    .pc_i   (ifid_pc),
    .inst_i (ifid_inst),
    .pc_o   (IFtoID_PC),
    .inst_o (IFtoID_inst),
    .valid_o(IFtoID_valid)
  );

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] bubble_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (ifid_load) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (!IFtoID_valid && !stall) bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: vector table, directed corner sequences, random run.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] IFtoID_PC;
  logic [31:0] IFtoID_inst;
  logic        IFtoID_valid;

  int total = 0;
  int bad   = 0;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_index   (jump_index),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .IFtoID_PC    (IFtoID_PC),
    .IFtoID_inst  (IFtoID_inst),
    .IFtoID_valid (IFtoID_valid)
  );

  always #5 clk = ~clk;

  // Never equals NOP for a word-aligned address (low two bits always 11).
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge; outputs are then pre-edge values.
  task automatic cyc(input logic s, input logic b, input logic [31:0] bt, input logic j,
                     input logic [25:0] ji, input logic a);
    @(negedge clk);
    stall         = s;
    branch_taken  = b;
    branch_target = bt;
    jump          = j;
    jump_index    = ji;
    imem_ack      = a & imem_req;
    imem_rdata    = mem_word(imem_addr);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; imem_ack = 1'b0;
    branch_target = '0; jump_index = '0; imem_rdata = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  typedef struct {
    logic        stall;
    logic        ack;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } vec_t;

  vec_t vecs[10];

  // Random-phase model state
  logic [31:0] exp_pc, m_pc, m_inst, o_pc, o_inst, tgt, bt, prev_addr;
  logic        m_valid, o_valid, s, b, j, redir, prev_req, prev_ack;
  logic [25:0] ji;
  int          deliveries;

  initial begin
    // Zero-wait fetch from reset, then a 3-cycle stall landing on the ack at 0x10.
    vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h04, 1'b1, 32'h04, mem_word(32'h00)};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h08, mem_word(32'h04)};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h0C, mem_word(32'h08)};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h10, mem_word(32'h0C)};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h10, mem_word(32'h0C)};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h10, mem_word(32'h0C)};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h10, mem_word(32'h0C)};
    vecs[9] = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h14, mem_word(32'h10)};

    do_reset();
    foreach (vecs[i]) begin
      cyc(vecs[i].stall, 1'b0, 32'h0, 1'b0, 26'h0, vecs[i].ack);
      chk($sformatf("vec%0d_req", i), imem_req, vecs[i].req);
      if (vecs[i].req) chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].addr);
      chk($sformatf("vec%0d_valid", i), IFtoID_valid, vecs[i].valid);
      chk($sformatf("vec%0d_pc", i), IFtoID_PC, vecs[i].pc);
      chk($sformatf("vec%0d_inst", i), IFtoID_inst, vecs[i].inst);
    end

    // Jump target takes region bits from IFtoID_PC.
    cyc(1'b0, 1'b1, 32'h4000_0004, 1'b0, 26'h0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1);
    chk("br_squash_valid", IFtoID_valid, 0);
    chk("br_addr", imem_addr, 32'h4000_0004);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 26'h000_0100, 1'b1);
    chk("jmp_pre_pc", IFtoID_PC, 32'h4000_0008);
    chk("jmp_pre_valid", IFtoID_valid, 1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1);
    chk("jmp_squash_valid", IFtoID_valid, 0);
    chk("jmp_squash_inst", IFtoID_inst, 32'h0);
    chk("jmp_addr", imem_addr, 32'h4000_0400);
    chk("jmp_req", imem_req, 1);

    // Branch beats jump and beats stall.
    cyc(1'b1, 1'b1, 32'h0000_0200, 1'b1, 26'h3FF_FFFF, 1'b1);
    chk("prio_pre_valid", IFtoID_valid, 1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0);
    chk("prio_addr", imem_addr, 32'h0000_0200);
    chk("prio_squash_valid", IFtoID_valid, 0);

    // Redirect while the request at 0x20 waits four cycles for its ack.
    cyc(1'b0, 1'b1, 32'h0000_0020, 1'b0, 26'h0, 1'b1);
    cyc(1'b0, 1'b1, 32'h0000_0080, 1'b0, 26'h0, 1'b0);
    chk("disc_addr0", imem_addr, 32'h20);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0);
      chk($sformatf("disc_req%0d", k), imem_req, 1);
      chk($sformatf("disc_addr%0d", k + 1), imem_addr, 32'h20);
      chk($sformatf("disc_valid%0d", k), IFtoID_valid, 0);
    end
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1);
    chk("disc_ack_addr", imem_addr, 32'h20);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1);
    chk("disc_next_addr", imem_addr, 32'h80);
    chk("disc_dropped", IFtoID_valid, 0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0);
    chk("disc_first_pc", IFtoID_PC, 32'h84);
    chk("disc_first_inst", IFtoID_inst, mem_word(32'h80));

    // PC wrap, then asynchronous reset in the middle of HOLD.
    cyc(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 26'h0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1);
    chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_pc", IFtoID_PC, 32'h0);
    chk("wrap_inst", IFtoID_inst, mem_word(32'hFFFF_FFFC));
    chk("wrap_valid", IFtoID_valid, 1);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1);
    chk("hold_req", imem_req, 0);
    #2 rst = 1'b0;
    #1;
    chk("arst_req", imem_req, 0);
    chk("arst_valid", IFtoID_valid, 0);
    chk("arst_pc", IFtoID_PC, 32'h0);
    chk("arst_inst", IFtoID_inst, 32'h0);
    chk("arst_addr", imem_addr, 32'h0);
    @(posedge clk);
    #2 rst = 1'b1;
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1);
    chk("restart_start_req", imem_req, 0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1);
    chk("restart_addr", imem_addr, 32'h0);
    chk("restart_req", imem_req, 1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1);
    chk("restart_pc", IFtoID_PC, 32'h4);
    chk("restart_inst", IFtoID_inst, mem_word(32'h0));

    // Random run: the delivered stream must follow program order through redirects.
    do_reset();
    exp_pc = 32'h0; m_pc = '0; m_inst = '0; m_valid = 1'b0;
    prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0; deliveries = 0;
    for (int n = 0; n < 800; n++) begin
      s  = 1'(($urandom % 4) == 0);
      b  = 1'(($urandom % 14) == 0);
      j  = 1'(($urandom % 14) == 0);
      bt = $urandom;
      ji = 26'($urandom);
      cyc(s, b, bt, j, ji, 1'($urandom % 2));
      if (prev_req && !prev_ack) begin
        chk("rnd_req_stable", imem_req, 1);
        chk("rnd_addr_stable", imem_addr, prev_addr);
      end
      if (imem_req) chk("rnd_align", {30'h0, imem_addr[1:0]}, 32'h0);
      prev_req = imem_req; prev_ack = imem_ack; prev_addr = imem_addr;
      redir = b | j;
      tgt = b ? {bt[31:2], 2'b00} : {m_pc[31:28], ji, 2'b00};
      o_pc = m_pc; o_inst = m_inst; o_valid = m_valid;
      @(posedge clk);
      #1;
      if (redir) begin
        chk("rnd_sq_valid", IFtoID_valid, 0);
        chk("rnd_sq_inst", IFtoID_inst, 32'h0);
        chk("rnd_sq_pc", IFtoID_PC, 32'h0);
        exp_pc = tgt; m_pc = '0; m_inst = '0; m_valid = 1'b0;
      end else if (s) begin
        chk("rnd_stall_valid", IFtoID_valid, o_valid);
        chk("rnd_stall_pc", IFtoID_PC, o_pc);
        chk("rnd_stall_inst", IFtoID_inst, o_inst);
      end else if (IFtoID_valid) begin
        chk("rnd_pc", IFtoID_PC, exp_pc + 32'd4);
        chk("rnd_inst", IFtoID_inst, mem_word(exp_pc));
        m_pc = exp_pc + 32'd4; m_inst = mem_word(exp_pc); m_valid = 1'b1;
        exp_pc = exp_pc + 32'd4;
        deliveries++;
      end else begin
        chk("rnd_bubble_inst", IFtoID_inst, 32'h0);
        chk("rnd_bubble_pc", IFtoID_PC, 32'h0);
        m_pc = '0; m_inst = '0; m_valid = 1'b0;
      end
    end
    chk("rnd_liveness", 32'(deliveries >= 40), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
